// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin AXI-lite arbiter: FSM encoding and response codes.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    POST = 2'd3
  } arb_state_t;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  // A watchdog expiry overrides whatever the slave reports.
  function automatic logic [1:0] pick_resp(input logic timed_out, input logic [1:0] slave_resp);
    return timed_out ? SLVERR : slave_resp;
  endfunction

endpackage

// File: rtl/arb_rr_picker.sv
// Combinational round-robin picker: the search starts at the index after ptr and wraps.
module arb_rr_picker #(
  parameter int N  = 2,
  parameter int PW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant
);

  localparam int unsigned NU = N;

  logic found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= NU; k++) begin
      for (int unsigned j = 0; j < NU; j++) begin
        if (!found && j == (32'(ptr) + k) % NU && req[j]) begin
          grant[j] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/axi_arbiter_rr.sv
// N-master to 1-slave AXI-lite arbiter, one transaction in flight, round-robin grant.
// Define ARB_TIMEOUT_EN to add a watchdog that answers SLVERR after TIMEOUT cycles.
module axi_arbiter_rr
  import arb_pkg::*;
#(
  parameter int N       = 2,
  parameter int AW      = 32,
  parameter int DW      = 64,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N-1:0]        m_arvalid_i,
  input  logic [N*AW-1:0]     m_araddr_i,
  output logic [N-1:0]        m_arready_o,
  output logic [N-1:0]        m_rvalid_o,
  input  logic [N-1:0]        m_rready_i,
  output logic [DW-1:0]       m_rdata_o,
  output logic [1:0]          m_rresp_o,
  input  logic [N-1:0]        m_awvalid_i,
  input  logic [N*AW-1:0]     m_awaddr_i,
  output logic [N-1:0]        m_awready_o,
  input  logic [N-1:0]        m_wvalid_i,
  input  logic [N*DW-1:0]     m_wdata_i,
  input  logic [N*(DW/8)-1:0] m_wstrb_i,
  output logic [N-1:0]        m_wready_o,
  output logic [N-1:0]        m_bvalid_o,
  input  logic [N-1:0]        m_bready_i,
  output logic [1:0]          m_bresp_o,
  output logic [AW-1:0]       s_araddr_o,
  output logic                s_arvalid_o,
  input  logic                s_arready_i,
  input  logic [DW-1:0]       s_rdata_i,
  input  logic [1:0]          s_rresp_i,
  input  logic                s_rvalid_i,
  output logic                s_rready_o,
  output logic [AW-1:0]       s_awaddr_o,
  output logic                s_awvalid_o,
  input  logic                s_awready_i,
  output logic [DW-1:0]       s_wdata_o,
  output logic [DW/8-1:0]     s_wstrb_o,
  output logic                s_wvalid_o,
  input  logic                s_wready_i,
  input  logic [1:0]          s_bresp_i,
  input  logic                s_bvalid_i,
  output logic                s_bready_o,
  output logic [N-1:0]        grant_o
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int SW = DW / 8;

  if (N < 2 || N > 8 || TIMEOUT < 1) begin : g_param_check
    $error("axi_arbiter_rr: unsupported N or TIMEOUT");
  end

  arb_state_t    state_q, state_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [PW-1:0] own_idx_q, own_idx_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic          ar_done_q, ar_done_d;
  logic          aw_done_q, aw_done_d;
  logic          w_done_q, w_done_d;

  logic [N-1:0]  req, winner;
  logic [PW-1:0] win_idx;
  logic          to_act;

  logic          own_arvalid, own_rready, own_awvalid, own_wvalid, own_bready;
  logic [AW-1:0] own_araddr, own_awaddr;
  logic [DW-1:0] own_wdata;
  logic [SW-1:0] own_wstrb;

  assign req     = m_arvalid_i | m_awvalid_i;
  assign grant_o = grant_q;

  arb_rr_picker #(.N(N), .PW(PW)) u_picker (
    .req   (req),
    .ptr   (ptr_q),
    .grant (winner)
  );

  always_comb begin
    win_idx = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (winner[i]) win_idx = PW'(i);
    end
  end

  always_comb begin
    own_arvalid = 1'b0;
    own_rready  = 1'b0;
    own_awvalid = 1'b0;
    own_wvalid  = 1'b0;
    own_bready  = 1'b0;
    own_araddr  = '0;
    own_awaddr  = '0;
    own_wdata   = '0;
    own_wstrb   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (grant_q[i]) begin
        own_arvalid = m_arvalid_i[i];
        own_rready  = m_rready_i[i];
        own_awvalid = m_awvalid_i[i];
        own_wvalid  = m_wvalid_i[i];
        own_bready  = m_bready_i[i];
        own_araddr  = m_araddr_i[i*AW +: AW];
        own_awaddr  = m_awaddr_i[i*AW +: AW];
        own_wdata   = m_wdata_i[i*DW +: DW];
        own_wstrb   = m_wstrb_i[i*SW +: SW];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    own_idx_d   = own_idx_q;
    ptr_d       = ptr_q;
    ar_done_d   = ar_done_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    m_arready_o = '0;
    m_rvalid_o  = '0;
    m_awready_o = '0;
    m_wready_o  = '0;
    m_bvalid_o  = '0;
    m_rdata_o   = s_rdata_i;
    m_rresp_o   = OKAY;
    m_bresp_o   = OKAY;
    s_araddr_o  = '0;
    s_arvalid_o = 1'b0;
    s_rready_o  = 1'b0;
    s_awaddr_o  = '0;
    s_awvalid_o = 1'b0;
    s_wdata_o   = '0;
    s_wstrb_o   = '0;
    s_wvalid_o  = 1'b0;
    s_bready_o  = 1'b0;
    case (state_q)
      IDLE: begin
        ar_done_d = 1'b0;
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        if (|req) begin
          grant_d   = winner;
          own_idx_d = win_idx;
          state_d   = (|(winner & m_arvalid_i)) ? RD : WR;
        end
      end
      RD: begin
        s_araddr_o = own_araddr;
        m_rresp_o  = pick_resp(to_act, s_rresp_i);
        if (to_act) begin
          m_rvalid_o = grant_q;
          if (own_rready) begin
            state_d = POST;
            grant_d = '0;
          end
        end else begin
          // The done flag keeps a still-asserted master arvalid from issuing twice.
          s_arvalid_o = own_arvalid & ~ar_done_q;
          m_arready_o = grant_q & {N{s_arready_i & ~ar_done_q}};
          if (own_arvalid && s_arready_i && !ar_done_q) ar_done_d = 1'b1;
          s_rready_o = own_rready;
          m_rvalid_o = grant_q & {N{s_rvalid_i}};
          if (s_rvalid_i && own_rready) begin
            state_d = POST;
            grant_d = '0;
          end
        end
      end
      WR: begin
        s_awaddr_o = own_awaddr;
        s_wdata_o  = own_wdata;
        s_wstrb_o  = own_wstrb;
        m_bresp_o  = pick_resp(to_act, s_bresp_i);
        if (to_act) begin
          m_bvalid_o = grant_q;
          if (own_bready) begin
            state_d = POST;
            grant_d = '0;
          end
        end else begin
          s_awvalid_o = own_awvalid & ~aw_done_q;
          m_awready_o = grant_q & {N{s_awready_i & ~aw_done_q}};
          if (own_awvalid && s_awready_i && !aw_done_q) aw_done_d = 1'b1;
          s_wvalid_o = own_wvalid & ~w_done_q;
          m_wready_o = grant_q & {N{s_wready_i & ~w_done_q}};
          if (own_wvalid && s_wready_i && !w_done_q) w_done_d = 1'b1;
          s_bready_o = own_bready;
          m_bvalid_o = grant_q & {N{s_bvalid_i}};
          if (s_bvalid_i && own_bready) begin
            state_d = POST;
            grant_d = '0;
          end
        end
      end
      POST: begin
        ptr_d   = own_idx_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      own_idx_q <= '0;
      ptr_q     <= PW'(N - 1);
      ar_done_q <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      own_idx_q <= own_idx_d;
      ptr_q     <= ptr_d;
      ar_done_q <= ar_done_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q;
  logic          to_q;

  assign to_act = to_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      to_q  <= 1'b0;
    end else if (state_q == RD || state_q == WR) begin
      if (!to_q && state_d != POST) begin
        if (cnt_q == CW'(TIMEOUT - 1)) to_q <= 1'b1;
        else                           cnt_q <= cnt_q + 1'b1;
      end
    end else begin
      cnt_q <= '0;
      to_q  <= 1'b0;
    end
  end
`else
  assign to_act = 1'b0;
`endif

endmodule

// File: tb/tb_axi_arbiter_rr.sv
// Directed self-checking bench for axi_arbiter_rr (N=2); the watchdog scenario needs ARB_TIMEOUT_EN.
module tb_axi_arbiter_rr;

  logic         clk;
  logic         rst;
  logic [1:0]   m_arvalid, m_arready, m_rvalid, m_rready;
  logic [63:0]  m_araddr, m_awaddr;
  logic [63:0]  m_rdata;
  logic [1:0]   m_rresp, m_bresp;
  logic [1:0]   m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic [127:0] m_wdata;
  logic [15:0]  m_wstrb;
  logic [31:0]  s_araddr, s_awaddr;
  logic         s_arvalid, s_arready, s_rvalid, s_rready;
  logic [63:0]  s_rdata, s_wdata;
  logic [1:0]   s_rresp, s_bresp;
  logic         s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic [7:0]   s_wstrb;
  logic [1:0]   grant;

  int vec_cnt = 0;
  int err_cnt = 0;

  axi_arbiter_rr #(.N(2), .AW(32), .DW(64), .TIMEOUT(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .m_arvalid_i (m_arvalid),
    .m_araddr_i  (m_araddr),
    .m_arready_o (m_arready),
    .m_rvalid_o  (m_rvalid),
    .m_rready_i  (m_rready),
    .m_rdata_o   (m_rdata),
    .m_rresp_o   (m_rresp),
    .m_awvalid_i (m_awvalid),
    .m_awaddr_i  (m_awaddr),
    .m_awready_o (m_awready),
    .m_wvalid_i  (m_wvalid),
    .m_wdata_i   (m_wdata),
    .m_wstrb_i   (m_wstrb),
    .m_wready_o  (m_wready),
    .m_bvalid_o  (m_bvalid),
    .m_bready_i  (m_bready),
    .m_bresp_o   (m_bresp),
    .s_araddr_o  (s_araddr),
    .s_arvalid_o (s_arvalid),
    .s_arready_i (s_arready),
    .s_rdata_i   (s_rdata),
    .s_rresp_i   (s_rresp),
    .s_rvalid_i  (s_rvalid),
    .s_rready_o  (s_rready),
    .s_awaddr_o  (s_awaddr),
    .s_awvalid_o (s_awvalid),
    .s_awready_i (s_awready),
    .s_wdata_o   (s_wdata),
    .s_wstrb_o   (s_wstrb),
    .s_wvalid_o  (s_wvalid),
    .s_wready_i  (s_wready),
    .s_bresp_i   (s_bresp),
    .s_bvalid_i  (s_bvalid),
    .s_bready_o  (s_bready),
    .grant_o     (grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic wait_grant(input string name, input logic [1:0] exp_g);
    int n;
    n = 0;
    do begin
      @(negedge clk); #1; n++;
    end while (grant === 2'b00 && n < 8);
    vec_cnt++; if (grant !== exp_g) begin err_cnt++; $display("FAIL %s: grant got %b want %b", name, grant, exp_g); end
  endtask

  task automatic serve_read(input logic [1:0] exp_g, input logic [31:0] exp_addr, input logic [63:0] data);
    wait_grant("rd_grant", exp_g);
    vec_cnt++; if (s_araddr !== exp_addr) begin err_cnt++; $display("FAIL rd_araddr: got %h want %h", s_araddr, exp_addr); end
    s_arready = 1'b1; #1;
    vec_cnt++; if (m_arready !== exp_g) begin err_cnt++; $display("FAIL rd_arready: got %b want %b", m_arready, exp_g); end
    @(negedge clk);
    s_arready = 1'b0; s_rvalid = 1'b1; s_rdata = data; #1;
    vec_cnt++; if (m_rvalid !== exp_g) begin err_cnt++; $display("FAIL rd_rvalid: got %b want %b", m_rvalid, exp_g); end
    vec_cnt++; if (m_rdata !== data) begin err_cnt++; $display("FAIL rd_rdata: got %h want %h", m_rdata, data); end
    @(negedge clk);
    s_rvalid = 1'b0;
  endtask

  task automatic test_reset;
    m_arvalid = 2'b11;
    repeat (2) @(negedge clk);
    #1;
    vec_cnt++; if (grant !== 2'b00) begin err_cnt++; $display("FAIL rst_grant: got %b want 00", grant); end
    vec_cnt++; if (s_arvalid !== 1'b0) begin err_cnt++; $display("FAIL rst_s_arvalid: got %b want 0", s_arvalid); end
    vec_cnt++; if (m_arready !== 2'b00) begin err_cnt++; $display("FAIL rst_m_arready: got %b want 00", m_arready); end
    vec_cnt++; if (s_araddr !== 32'h0) begin err_cnt++; $display("FAIL rst_s_araddr: got %h want 0", s_araddr); end
    vec_cnt++; if ({s_awvalid, s_wvalid, s_rready, s_bready} !== 4'b0000) begin err_cnt++; $display("FAIL rst_s_ctrl: got %b want 0000", {s_awvalid, s_wvalid, s_rready, s_bready}); end
    @(negedge clk);
    m_arvalid = 2'b00;
    rst = 1'b1;
  endtask

  task automatic test_single_read;
    @(negedge clk);
    m_arvalid = 2'b01; m_araddr[31:0] = 32'h8000_0000; m_rready = 2'b01; #1;
    vec_cnt++; if (grant !== 2'b00) begin err_cnt++; $display("FAIL sr_grant_latency: got %b want 00", grant); end
    @(negedge clk); #1;
    vec_cnt++; if (grant !== 2'b01) begin err_cnt++; $display("FAIL sr_grant: got %b want 01", grant); end
    vec_cnt++; if (s_arvalid !== 1'b1) begin err_cnt++; $display("FAIL sr_s_arvalid: got %b want 1", s_arvalid); end
    vec_cnt++; if (s_araddr !== 32'h8000_0000) begin err_cnt++; $display("FAIL sr_s_araddr: got %h want 80000000", s_araddr); end
    vec_cnt++; if (m_arready !== 2'b00) begin err_cnt++; $display("FAIL sr_arready_wait: got %b want 00", m_arready); end
    s_arready = 1'b1; #1;
    vec_cnt++; if (m_arready !== 2'b01) begin err_cnt++; $display("FAIL sr_arready: got %b want 01", m_arready); end
    @(negedge clk);
    s_arready = 1'b0; #1;
    vec_cnt++; if (s_arvalid !== 1'b0) begin err_cnt++; $display("FAIL sr_ar_once: got %b want 0", s_arvalid); end
    m_arvalid = 2'b00; s_rvalid = 1'b1; s_rdata = 64'h1234; #1;
    vec_cnt++; if (m_rvalid !== 2'b01) begin err_cnt++; $display("FAIL sr_m_rvalid: got %b want 01", m_rvalid); end
    vec_cnt++; if (m_rdata !== 64'h1234) begin err_cnt++; $display("FAIL sr_m_rdata: got %h want 1234", m_rdata); end
    vec_cnt++; if (s_rready !== 1'b1) begin err_cnt++; $display("FAIL sr_s_rready: got %b want 1", s_rready); end
    @(negedge clk); #1;
    vec_cnt++; if (m_rvalid !== 2'b00) begin err_cnt++; $display("FAIL sr_post_rvalid: got %b want 00", m_rvalid); end
    vec_cnt++; if (s_rready !== 1'b0) begin err_cnt++; $display("FAIL sr_post_rready: got %b want 0", s_rready); end
    vec_cnt++; if (grant !== 2'b00) begin err_cnt++; $display("FAIL sr_post_grant: got %b want 00", grant); end
    @(negedge clk);
    s_rvalid = 1'b0; #1;
    vec_cnt++; if (grant !== 2'b00) begin err_cnt++; $display("FAIL sr_idle_grant: got %b want 00", grant); end
  endtask

  task automatic test_write_w_first;
    int aw_hs, w_hs;
    aw_hs = 0; w_hs = 0;
    @(negedge clk);
    m_wvalid = 2'b10; m_wdata[127:64] = 64'hCAFE_F00D_0000_0001; m_wstrb[15:8] = 8'hFF; m_bready = 2'b10;
    s_wready = 1'b1; #1;
    vec_cnt++; if (grant !== 2'b00) begin err_cnt++; $display("FAIL wr_w_alone_grant: got %b want 00", grant); end
    @(negedge clk);
    @(negedge clk);
    m_awvalid = 2'b10; m_awaddr[63:32] = 32'h0000_0100;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      s_awready = (c >= 2);
      #1;
      if (c == 0) begin
        vec_cnt++; if (grant !== 2'b10) begin err_cnt++; $display("FAIL wr_grant: got %b want 10", grant); end
        vec_cnt++; if (s_wstrb !== 8'hFF) begin err_cnt++; $display("FAIL wr_wstrb: got %h want ff", s_wstrb); end
        vec_cnt++; if (s_wdata !== 64'hCAFE_F00D_0000_0001) begin err_cnt++; $display("FAIL wr_wdata: got %h want cafef00d00000001", s_wdata); end
        vec_cnt++; if (m_wready !== 2'b10) begin err_cnt++; $display("FAIL wr_wready: got %b want 10", m_wready); end
      end
      if (c == 2) begin
        vec_cnt++; if (s_awaddr !== 32'h100) begin err_cnt++; $display("FAIL wr_awaddr: got %h want 100", s_awaddr); end
        vec_cnt++; if (m_awready !== 2'b10) begin err_cnt++; $display("FAIL wr_awready: got %b want 10", m_awready); end
      end
      if (s_awvalid && s_awready) aw_hs++;
      if (s_wvalid && s_wready) w_hs++;
    end
    m_awvalid = 2'b00; m_wvalid = 2'b00; s_awready = 1'b0; s_wready = 1'b0;
    s_bvalid = 1'b1; s_bresp = 2'b00; #1;
    vec_cnt++; if (m_bvalid !== 2'b10) begin err_cnt++; $display("FAIL wr_bvalid: got %b want 10", m_bvalid); end
    vec_cnt++; if (m_bresp !== 2'b00) begin err_cnt++; $display("FAIL wr_bresp: got %b want 00", m_bresp); end
    @(negedge clk);
    s_bvalid = 1'b0; m_bready = 2'b00; #1;
    vec_cnt++; if (aw_hs !== 1) begin err_cnt++; $display("FAIL wr_aw_count: got %0d want 1", aw_hs); end
    vec_cnt++; if (w_hs !== 1) begin err_cnt++; $display("FAIL wr_w_count: got %0d want 1", w_hs); end
  endtask

  task automatic test_round_robin;
    @(negedge clk);
    m_arvalid = 2'b11; m_rready = 2'b11;
    m_araddr = {32'h0000_2000, 32'h0000_1000};
    serve_read(2'b01, 32'h0000_1000, 64'hA0);
    serve_read(2'b10, 32'h0000_2000, 64'hA1);
    serve_read(2'b01, 32'h0000_1000, 64'hA2);
    serve_read(2'b10, 32'h0000_2000, 64'hA3);
    m_arvalid = 2'b00; m_rready = 2'b00;
  endtask

  task automatic test_read_before_write;
    @(negedge clk);
    m_arvalid = 2'b01; m_awvalid = 2'b01; m_wvalid = 2'b01;
    m_araddr[31:0] = 32'h40; m_awaddr[31:0] = 32'h80;
    m_wdata[63:0] = 64'h55; m_wstrb[7:0] = 8'h0F; m_rready = 2'b01; m_bready = 2'b01;
    wait_grant("rw_rd_grant", 2'b01);
    vec_cnt++; if ({s_arvalid, s_awvalid} !== 2'b10) begin err_cnt++; $display("FAIL rw_read_first: got %b want 10", {s_arvalid, s_awvalid}); end
    s_arready = 1'b1;
    @(negedge clk);
    s_arready = 1'b0; s_rvalid = 1'b1; s_rdata = 64'h77; #1;
    vec_cnt++; if (m_rvalid !== 2'b01) begin err_cnt++; $display("FAIL rw_rvalid: got %b want 01", m_rvalid); end
    @(negedge clk);
    s_rvalid = 1'b0; m_arvalid = 2'b00;
    wait_grant("rw_wr_grant", 2'b01);
    vec_cnt++; if ({s_arvalid, s_awvalid} !== 2'b01) begin err_cnt++; $display("FAIL rw_write_next: got %b want 01", {s_arvalid, s_awvalid}); end
    vec_cnt++; if (s_awaddr !== 32'h80) begin err_cnt++; $display("FAIL rw_awaddr: got %h want 80", s_awaddr); end
    s_awready = 1'b1; s_wready = 1'b1; #1;
    vec_cnt++; if ({m_awready, m_wready} !== 4'b0101) begin err_cnt++; $display("FAIL rw_aw_w_ready: got %b want 0101", {m_awready, m_wready}); end
    @(negedge clk);
    s_awready = 1'b0; s_wready = 1'b0; m_awvalid = 2'b00; m_wvalid = 2'b00; s_bvalid = 1'b1; #1;
    vec_cnt++; if (m_bvalid !== 2'b01) begin err_cnt++; $display("FAIL rw_bvalid: got %b want 01", m_bvalid); end
    @(negedge clk);
    s_bvalid = 1'b0; m_rready = 2'b00; m_bready = 2'b00;
  endtask

  task automatic test_reset_mid_read;
    @(negedge clk);
    m_arvalid = 2'b10; m_araddr[63:32] = 32'h300; m_rready = 2'b10;
    wait_grant("mr_grant_before", 2'b10);
    rst = 1'b0; s_rvalid = 1'b1; #1;
    vec_cnt++; if (grant !== 2'b00) begin err_cnt++; $display("FAIL mr_grant_async: got %b want 00", grant); end
    vec_cnt++; if ({s_arvalid, m_rvalid} !== 3'b000) begin err_cnt++; $display("FAIL mr_outputs_async: got %b want 000", {s_arvalid, m_rvalid}); end
    @(negedge clk);
    rst = 1'b1; m_arvalid = 2'b11; m_araddr[31:0] = 32'h200; m_rready = 2'b11; #1;
    vec_cnt++; if (m_rvalid !== 2'b00) begin err_cnt++; $display("FAIL mr_stale_rvalid: got %b want 00", m_rvalid); end
    #2;
    s_rvalid = 1'b0;
    serve_read(2'b01, 32'h200, 64'hBEEF);
    m_arvalid = 2'b00; m_rready = 2'b00;
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout;
    @(negedge clk);
    m_arvalid = 2'b01; m_araddr[31:0] = 32'h500; m_rready = 2'b00;
    wait_grant("to_grant", 2'b01);
    s_arready = 1'b1;
    @(negedge clk);
    s_arready = 1'b0; m_arvalid = 2'b00;
    repeat (5) @(negedge clk);
    @(negedge clk); #1;
    vec_cnt++; if (m_rvalid !== 2'b00) begin err_cnt++; $display("FAIL to_early: got %b want 00", m_rvalid); end
    @(negedge clk); #1;
    vec_cnt++; if (m_rvalid !== 2'b01) begin err_cnt++; $display("FAIL to_rvalid: got %b want 01", m_rvalid); end
    vec_cnt++; if (m_rresp !== 2'b10) begin err_cnt++; $display("FAIL to_rresp: got %b want 10", m_rresp); end
    @(negedge clk); #1;
    vec_cnt++; if (m_rvalid !== 2'b01) begin err_cnt++; $display("FAIL to_hold: got %b want 01", m_rvalid); end
    m_rready = 2'b01;
    @(negedge clk); #1;
    vec_cnt++; if ({grant, m_rvalid} !== 4'b0000) begin err_cnt++; $display("FAIL to_post: got %b want 0000", {grant, m_rvalid}); end
    m_rready = 2'b00;
  endtask
`endif

  initial begin
    rst = 1'b0;
    m_arvalid = '0; m_araddr = '0; m_rready = '0;
    m_awvalid = '0; m_awaddr = '0; m_wvalid = '0; m_wdata = '0; m_wstrb = '0; m_bready = '0;
    s_arready = 1'b0; s_rdata = '0; s_rresp = 2'b00; s_rvalid = 1'b0;
    s_awready = 1'b0; s_wready = 1'b0; s_bresp = 2'b00; s_bvalid = 1'b0;
    test_reset;
    test_single_read;
    test_write_w_first;
    test_round_robin;
    test_read_before_write;
    test_reset_mid_read;
`ifdef ARB_TIMEOUT_EN
    test_timeout;
`endif
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, vectors %0d", vec_cnt);
    $fatal(1);
  end

endmodule
